// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state type, default sizes and width helper shared by the push arbiter
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;
  localparam int WIDTH = 8;
  localparam int NREQ = 4;
  localparam int STALL_MAX = 7;
  function automatic int clog2w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick: combinational round-robin search over unmasked requests, starting after last
module fifo_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int L2N = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [L2N-1:0]  last,
  output logic            found,
  output logic [L2N-1:0]  idx
);
  logic [NREQ-1:0] cand;
  logic [L2N-1:0] j;
  assign cand = req & ~mask;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = L2N'((int'(last) + k) % NREQ);
      if (cand[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin sharing of one FIFO push port; FIFO_ARB_STALL_EN adds a sticky stall watchdog
module fifo_push_arb #(
  parameter int WIDTH = fifo_arb_pkg::WIDTH,
  parameter int NREQ = fifo_arb_pkg::NREQ,
  parameter int L2N = fifo_arb_pkg::clog2w(NREQ)
`ifdef FIFO_ARB_STALL_EN
  ,
  parameter int STALL_MAX = fifo_arb_pkg::STALL_MAX
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  output logic                  push_req,
  output logic [WIDTH-1:0]      push_data,
  input  logic                  push_ack,
  output logic [L2N-1:0]        grant_id,
  output logic                  busy
`ifdef FIFO_ARB_STALL_EN
  ,
  output logic                  stall_err
`endif
);
  import fifo_arb_pkg::*;
  arb_state_e state_q, state_d;
  logic push_req_q, push_req_d, done, found, load;
  logic [WIDTH-1:0] data_q, data_d;
  logic [L2N-1:0] gid_q, gid_d, last_q, last_d, idx;
  logic [NREQ-1:0] own;
  logic [WIDTH-1:0] slices [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slices[g] = req_data[g*WIDTH +: WIDTH];
  end
  assign busy = state_q == ARB_WAIT;
  assign own = NREQ'(1) << gid_q;
  assign done = push_req_q & push_ack;
  assign req_ack = own & {NREQ{done}};
  assign push_req = push_req_q;
  assign push_data = data_q;
  assign grant_id = gid_q;
  fifo_arb_rr_pick #(.NREQ(NREQ), .L2N(L2N)) u_pick (
    .req(req_valid),
    .mask(busy ? own : '0),
    .last(busy ? gid_q : last_q),
    .found(found),
    .idx(idx)
  );
  always_comb begin
    load = (!busy || done) && found;
    state_d = load ? ARB_WAIT : done ? ARB_IDLE : state_q;
    push_req_d = load | (push_req_q & ~done);
    gid_d = load ? idx : gid_q;
    data_d = load ? slices[idx] : data_q;
    last_d = done ? gid_q : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      push_req_q <= 1'b0;
      data_q <= '0;
      gid_q <= '0;
      last_q <= L2N'(NREQ - 1);
    end else begin
      state_q <= state_d;
      push_req_q <= push_req_d;
      data_q <= data_d;
      gid_q <= gid_d;
      last_q <= last_d;
    end
  end
`ifdef FIFO_ARB_STALL_EN
  localparam int CW = clog2w(STALL_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_comb begin
    cnt_d = (!busy || done) ? '0 : (cnt_q == CW'(STALL_MAX)) ? cnt_q : cnt_q + 1'b1;
    err_d = err_q | (cnt_q == CW'(STALL_MAX));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign stall_err = err_q;
`endif
endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb: directed vector table plus randomized run against a round-robin reference model
module tb_fifo_push_arb;
  localparam int W = 8;
  localparam int N = 4;
  localparam int SMAX = 7;
  typedef struct {
    logic rst;
    logic [N-1:0] v;
    logic ack;
    logic ereq;
    logic [W-1:0] edata;
    logic [1:0] egid;
    logic [N-1:0] erack;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ack;
  logic push_req, push_ack = 1'b0, busy;
  logic [W-1:0] push_data;
  logic [1:0] grant_id;
`ifdef FIFO_ARB_STALL_EN
  logic stall_err;
`endif
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  fifo_push_arb dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ack(req_ack),
    .push_req(push_req),
    .push_data(push_data),
    .push_ack(push_ack),
    .grant_id(grant_id),
    .busy(busy)
`ifdef FIFO_ARB_STALL_EN
    ,
    .stall_err(stall_err)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apply(input logic r, input logic [N-1:0] v, input logic a);
    @(negedge clk);
    reset = r;
    req_valid = v;
    push_ack = a;
    #1;
  endtask
  task automatic row(input logic r, input logic [N-1:0] v, input logic a, input logic q, input logic [W-1:0] d, input logic [1:0] g, input logic [N-1:0] k);
    vec_t t;
    t.rst = r; t.v = v; t.ack = a; t.ereq = q; t.edata = d; t.egid = g; t.erack = k;
    tbl.push_back(t);
  endtask
  function automatic int pick(input logic [N-1:0] r, input int last);
    logic [1:0] j;
    for (int k = 1; k <= N; k++) begin
      j = 2'((last + k) % N);
      if (r[j]) return int'(j);
    end
    return -1;
  endfunction
  initial begin
    logic [N-1:0] v, acked, rk, vm;
    logic [N*W-1:0] dpk;
    logic a, m_busy, m_err;
    int m_gid, m_last, m_sn, w;
    logic [W-1:0] m_data;
    row(1'b0, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
    row(1'b0, 4'b0100, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
    row(1'b0, 4'b0100, 1'b1, 1'b1, 8'hA5, 2'd2, 4'b0100);
    row(1'b0, 4'b0000, 1'b1, 1'b0, 8'hA5, 2'd2, 4'b0000);
    row(1'b1, 4'b0000, 1'b1, 1'b0, 8'hA5, 2'd2, 4'b0000);
    row(1'b0, 4'b1111, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
    row(1'b0, 4'b1111, 1'b1, 1'b1, 8'h11, 2'd0, 4'b0001);
    row(1'b0, 4'b1111, 1'b1, 1'b1, 8'h3C, 2'd1, 4'b0010);
    row(1'b0, 4'b1111, 1'b1, 1'b1, 8'hA5, 2'd2, 4'b0100);
    row(1'b0, 4'b1111, 1'b1, 1'b1, 8'h33, 2'd3, 4'b1000);
    row(1'b0, 4'b1111, 1'b0, 1'b1, 8'h11, 2'd0, 4'b0000);
    row(1'b1, 4'b1111, 1'b0, 1'b1, 8'h11, 2'd0, 4'b0000);
    row(1'b0, 4'b1111, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000);
    row(1'b0, 4'b1111, 1'b1, 1'b1, 8'h11, 2'd0, 4'b0001);
    for (int i = 0; i < 5; i++) row(1'b0, 4'b1110, 1'b0, 1'b1, 8'h3C, 2'd1, 4'b0000);
    row(1'b0, 4'b1110, 1'b1, 1'b1, 8'h3C, 2'd1, 4'b0010);
    row(1'b0, 4'b1100, 1'b1, 1'b1, 8'hA5, 2'd2, 4'b0100);
    row(1'b0, 4'b1000, 1'b1, 1'b1, 8'h33, 2'd3, 4'b1000);
    row(1'b0, 4'b1000, 1'b1, 1'b0, 8'h33, 2'd3, 4'b0000);
    row(1'b0, 4'b1000, 1'b1, 1'b1, 8'h33, 2'd3, 4'b1000);
    row(1'b0, 4'b1000, 1'b1, 1'b0, 8'h33, 2'd3, 4'b0000);
    row(1'b0, 4'b1000, 1'b1, 1'b1, 8'h33, 2'd3, 4'b1000);
    row(1'b0, 4'b0000, 1'b0, 1'b0, 8'h33, 2'd3, 4'b0000);
    req_data = 32'h33A53C11;
    apply(1'b1, '0, 1'b0);
    apply(1'b1, '0, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].ack);
      chk($sformatf("tbl[%0d].push_req", i), 32'(push_req), 32'(tbl[i].ereq));
      chk($sformatf("tbl[%0d].busy", i), 32'(busy), 32'(tbl[i].ereq));
      chk($sformatf("tbl[%0d].push_data", i), 32'(push_data), 32'(tbl[i].edata));
      chk($sformatf("tbl[%0d].grant_id", i), 32'(grant_id), 32'(tbl[i].egid));
      chk($sformatf("tbl[%0d].req_ack", i), 32'(req_ack), 32'(tbl[i].erack));
    end
`ifdef FIFO_ARB_STALL_EN
    apply(1'b1, '0, 1'b0);
    apply(1'b0, 4'b0001, 1'b0);
    for (int k = 0; k < 7; k++) apply(1'b0, 4'b0001, 1'b0);
    apply(1'b0, 4'b0001, 1'b0);
    chk("stall8_pre", 32'(stall_err), 32'd0);
    apply(1'b0, 4'b0001, 1'b1);
    chk("stall8_set", 32'(stall_err), 32'd1);
    chk("stall8_ack", 32'(req_ack), 32'd1);
    apply(1'b0, 4'b0000, 1'b0);
    chk("stall8_sticky", 32'(stall_err), 32'd1);
    apply(1'b1, '0, 1'b0);
    apply(1'b0, 4'b0001, 1'b0);
    chk("stall_reset", 32'(stall_err), 32'd0);
    for (int k = 0; k < 6; k++) apply(1'b0, 4'b0001, 1'b0);
    apply(1'b0, 4'b0001, 1'b1);
    chk("stall6_ack", 32'(req_ack), 32'd1);
    chk("stall6_clear", 32'(stall_err), 32'd0);
    apply(1'b0, 4'b0000, 1'b0);
    chk("stall6_after", 32'(stall_err), 32'd0);
`endif
    apply(1'b1, '0, 1'b0);
    m_busy = 1'b0; m_err = 1'b0; m_gid = 0; m_last = N - 1; m_sn = 0; m_data = '0;
    v = '0; acked = '0; dpk = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (((v | acked) & (N'(1) << i)) != (v & (N'(1) << i)) || (v & (N'(1) << i)) == '0) begin
          v = (v & ~(N'(1) << i)) | (N'($urandom_range(0, 2) != 0) << i);
          dpk = (dpk & ~(32'hFF << (i * W))) | ((32'($urandom) & 32'hFF) << (i * W));
        end
      end
      a = $urandom_range(0, 9) < 6;
      @(negedge clk);
      reset = 1'b0;
      req_valid = v;
      req_data = dpk;
      push_ack = a;
      #1;
      rk = (m_busy && a) ? N'(1) << m_gid : '0;
      chk($sformatf("rnd[%0d].push_req", c), 32'(push_req), 32'(m_busy));
      chk($sformatf("rnd[%0d].busy", c), 32'(busy), 32'(m_busy));
      chk($sformatf("rnd[%0d].push_data", c), 32'(push_data), 32'(m_data));
      chk($sformatf("rnd[%0d].grant_id", c), 32'(grant_id), 32'(m_gid));
      chk($sformatf("rnd[%0d].req_ack", c), 32'(req_ack), 32'(rk));
`ifdef FIFO_ARB_STALL_EN
      chk($sformatf("rnd[%0d].stall_err", c), 32'(stall_err), 32'(m_err));
`endif
      if (m_busy && m_sn >= SMAX) m_err = 1'b1;
      w = -1;
      if (m_busy && a) begin
        m_last = m_gid;
        vm = v & ~(N'(1) << m_gid);
        w = pick(vm, m_last);
      end else if (!m_busy) w = pick(v, m_last);
      if (w >= 0) begin
        m_data = W'(dpk >> (w * W));
        m_busy = 1'b1; m_gid = w; m_sn = 0;
      end else if (m_busy && a) begin
        m_busy = 1'b0; m_sn = 0;
      end else if (m_busy) m_sn++;
      acked = rk;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin arbiter that shares the single push port of the FIFO between NREQ producers. Each producer presents data with a valid/ack handshake; the arbiter selects one, drives the FIFO push_req/data_in pair and holds it stable until push_ack, then returns the ack to the winning producer. An optional watchdog flags a push that stalls too long, for example against a full FIFO.

## Interface
- WIDTH, 8, data width; matches the FIFO.
- NREQ, 4, number of producers; range 2..16.
- L2N, 2, clog2(NREQ); width of the grant index.
- STALL_MAX, 7, watchdog limit in WAIT cycles without push_ack.
- clk  in  1  clock; all logic rises on posedge clk.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-producer request.
- req_data  in  NREQ*WIDTH  producer i data at bits [i*WIDTH +: WIDTH].
- req_ack  out  NREQ  one-hot accept pulse to the granted producer.
- push_req  out  1  to FIFO push_req.
- push_data  out  WIDTH  to FIFO data_in.
- push_ack  in  1  from FIFO push_ack.
- grant_id  out  L2N  index of the producer currently owning the port.
- busy  out  1  high while in WAIT.
- stall_err  out  1  sticky watchdog flag; exists only with the macro.

## Operation
- Producer rule: once req_valid[i] is high, it and its data slice stay stable until req_ack[i] is seen. Violations are out of scope.
- FSM with two states.
  - IDLE: push_req=0. If any req_valid, pick the winner with the round-robin search, register grant_id and push_data from the winner's slice, set push_req=1, go to WAIT.
  - WAIT: push_req, push_data and grant_id are held unchanged. When push_req && push_ack, the handshake completes.
- On completion:
  - req_ack[grant_id]=1 combinationally in that cycle: req_ack = onehot(grant_id) & {NREQ{push_req & push_ack}}.
  - The last-grant pointer is updated to grant_id.
  - Back-to-back: in the same cycle, re-arbitrate among req_valid with bit grant_id masked, because the current producer is still asserting valid.
    - If a candidate exists: load it and stay in WAIT, so push_req stays 1.
    - Otherwise: go to IDLE, so push_req=0 next cycle.
- Round-robin search starts at last_grant+1 and wraps modulo NREQ. After reset, last_grant=NREQ-1, so producer 0 has first priority.
- full is not an input. The arbiter relies on the FIFO withholding push_ack while full, so push_req stays held through a full FIFO.
- Reset values: state=IDLE, push_req=0, push_data=0, grant_id=0, busy=0, req_ack=0, last_grant=NREQ-1, stall_err=0, stall counter=0.
- Reset asserted mid-WAIT drops push_req the next cycle with no ack issued. The producer keeps its request and is re-served after reset.

## Timing
- Latency from req_valid rising, in IDLE, to push_req=1 is 1 cycle.
- Sustained throughput is 1 push per cycle when the FIFO acks every cycle and at least two producers are requesting.
- A single producer is served every 2 cycles. Its own ack cycle masks it out, so the FSM passes through IDLE.
- req_ack has zero latency from push_ack. push_req and push_data are registered outputs.

## Configuration
- FIFO_ARB_STALL_EN defined:
  - A counter of width clog2(STALL_MAX+1) resets to 0 on entering WAIT or on an ack, and increments each WAIT cycle without push_ack, saturating at STALL_MAX.
  - stall_err sets on the cycle after the counter reaches STALL_MAX and stays set until reset.
  - push_req is never dropped by the watchdog, to keep the FIFO hold-stable contract.
- Not defined: the counter and the stall_err port are absent and behaviour is otherwise identical.

## Structure
- Package fifo_arb_pkg holds:
  - the state typedef (ARB_IDLE, ARB_WAIT);
  - the default constants WIDTH, NREQ and STALL_MAX;
  - a function for the clog2 width helper.
- Sub-module fifo_arb_rr_pick is a purely combinational round-robin selector.
  - Inputs: request vector, mask, last_grant.
  - Outputs: found and idx.
  - It is instantiated once and serves both the IDLE and the back-to-back search.

## Test plan
- Single request: req_valid=4'b0100, data slice 2=8'hA5, push_ack tied 1.
  - Expect push_req=1 and push_data=A5 at cycle+1, grant_id=2, req_ack=4'b0100 that cycle.
  - Expect push_req=0 the next cycle.
- All four requesting continuously, ack always 1: grant order 0,1,2,3,0 with push_req held high for 5 consecutive cycles.
- Hold through full: grant producer 1 with data 8'h3C and push_ack=0 for 5 cycles.
  - push_req, push_data and grant_id must stay constant and req_ack must stay 0.
  - On the 6th cycle push_ack=1 gives req_ack=4'b0010.
- Masked re-arbitration: only producer 3 requesting, ack always 1. Expect push_req pattern 1,0,1,0 and grant_id=3 each time.
- Reset mid-WAIT: reset=1 while push_req=1. Expect push_req=0, busy=0 and grant_id=0 next cycle, with no req_ack pulse.
- With FIFO_ARB_STALL_EN and STALL_MAX=7:
  - push_ack=0 for 8 cycles in WAIT sets stall_err=1, which stays 1 after a later ack.
  - A run of 6 stall cycles followed by an ack leaves stall_err=0.
